// File: rtl/conf_div_arbiter.sv
// Round-robin front end that shares one non-stalling conf_disp_divide pipeline between
// NUM_REQ streams, with a tag pipe and per-requester credit-protected response FIFOs.
module conf_div_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DISP_BITS   = 5,
    parameter int DIV_LATENCY = 6,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic [NUM_REQ-1:0]                 i_req_valid,
    output logic [NUM_REQ-1:0]                 o_req_ready,
    input  logic [NUM_REQ*8-1:0]               i_req_conf,
    input  logic [NUM_REQ*(8+DISP_BITS)-1:0]   i_req_conf_disp,
    output logic                               o_div_valid,
    output logic [7:0]                         o_div_conf,
    output logic [8+DISP_BITS-1:0]             o_div_conf_disp,
    input  logic                               i_div_out_valid,
    input  logic [DISP_BITS-1:0]               i_div_out_disp,
    input  logic [7:0]                         i_div_out_conf,
    output logic [NUM_REQ-1:0]                 o_rsp_valid,
    input  logic [NUM_REQ-1:0]                 i_rsp_ready,
    output logic [NUM_REQ*DISP_BITS-1:0]       o_rsp_disp,
    output logic [NUM_REQ*8-1:0]               o_rsp_conf,
    output logic                               o_err_unexpected
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CDW   = 8 + DISP_BITS;
    localparam int CRW   = $clog2(FIFO_DEPTH + 1);
    localparam int PTW   = $clog2(FIFO_DEPTH);
    localparam int ENTW  = DISP_BITS + 8;

    logic [NUM_REQ-1:0] w_eligible;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_push;
    logic [NUM_REQ-1:0] w_pop;
    logic               w_grant_any;
    logic [TAG_W-1:0]   w_grant_idx;
    logic [TAG_W:0]     w_scan_sum;
    logic [TAG_W-1:0]   w_scan_idx;
    logic [7:0]         w_sel_conf;
    logic [CDW-1:0]     w_sel_conf_disp;

    logic [TAG_W-1:0]   r_rr_ptr;
    logic               r_div_valid;
    logic [7:0]         r_div_conf;
    logic [CDW-1:0]     r_div_conf_disp;
    logic [TAG_W-1:0]   r_div_tag;
    logic               r_tag_vld [DIV_LATENCY];
    logic [TAG_W-1:0]   r_tag_id  [DIV_LATENCY];
    logic               r_err;

    logic               w_ret_vld;
    logic [TAG_W-1:0]   w_ret_tag;

    // Scan from the round-robin pointer, wrapping, and take the first eligible requester.
    always_comb begin
        w_grant     = '0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan_sum  = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_sum = {1'b0, r_rr_ptr} + (TAG_W+1)'(k);
            if (w_scan_sum >= (TAG_W+1)'(NUM_REQ)) begin
                w_scan_sum = w_scan_sum - (TAG_W+1)'(NUM_REQ);
            end
            w_scan_idx = w_scan_sum[TAG_W-1:0];
            if (!w_grant_any && w_eligible[w_scan_idx]) begin
                w_grant_any         = 1'b1;
                w_grant_idx         = w_scan_idx;
                w_grant[w_scan_idx] = 1'b1;
            end
        end
    end

    assign o_req_ready     = w_grant;
    assign w_sel_conf      = i_req_conf[int'(w_grant_idx)*8 +: 8];
    assign w_sel_conf_disp = i_req_conf_disp[int'(w_grant_idx)*CDW +: CDW];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr_ptr        <= '0;
            r_div_valid     <= 1'b0;
            r_div_conf      <= '0;
            r_div_conf_disp <= '0;
            r_div_tag       <= '0;
        end else begin
            r_div_valid <= w_grant_any;
            if (w_grant_any) begin
                r_rr_ptr        <= (w_grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + TAG_W'(1);
                r_div_conf      <= w_sel_conf;
                r_div_conf_disp <= w_sel_conf_disp;
                r_div_tag       <= w_grant_idx;
            end
        end
    end

    assign o_div_valid     = r_div_valid;
    assign o_div_conf      = r_div_conf;
    assign o_div_conf_disp = r_div_conf_disp;

    // Tag pipe mirrors the divider depth so its tail lines up with i_div_out_valid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s < DIV_LATENCY; s++) begin
                r_tag_vld[s] <= 1'b0;
                r_tag_id[s]  <= '0;
            end
        end else begin
            r_tag_vld[0] <= r_div_valid;
            r_tag_id[0]  <= r_div_tag;
            for (int s = 1; s < DIV_LATENCY; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    assign w_ret_vld = r_tag_vld[DIV_LATENCY-1];
    assign w_ret_tag = r_tag_id[DIV_LATENCY-1];

    // Any disagreement between divider output and tag pipe means a lost or phantom result.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err <= 1'b0;
        end else if (i_div_out_valid != w_ret_vld) begin
            r_err <= 1'b1;
        end
    end

    assign o_err_unexpected = r_err;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            logic [CRW-1:0]  r_credit;
            logic [CRW-1:0]  r_count;
            logic [PTW-1:0]  r_wr_ptr;
            logic [PTW-1:0]  r_rd_ptr;
            logic [ENTW-1:0] r_mem [FIFO_DEPTH];
            logic [ENTW-1:0] w_head;

            assign w_eligible[gi] = i_req_valid[gi] && (r_credit < CRW'(FIFO_DEPTH));
            assign w_push[gi]     = i_div_out_valid && w_ret_vld && (w_ret_tag == TAG_W'(gi));
            assign w_pop[gi]      = (r_count != '0) && i_rsp_ready[gi];

            // Credits cover both in-flight and queued entries, so a push never finds the FIFO full.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_credit <= '0;
                end else begin
                    case ({w_grant[gi], w_pop[gi]})
                        2'b10:   r_credit <= r_credit + CRW'(1);
                        2'b01:   r_credit <= r_credit - CRW'(1);
                        default: r_credit <= r_credit;
                    endcase
                end
            end

            always_ff @(posedge i_clk) begin
                if (w_push[gi]) begin
                    r_mem[r_wr_ptr] <= {i_div_out_disp, i_div_out_conf};
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[gi]) begin
                        r_wr_ptr <= r_wr_ptr + PTW'(1);
                    end
                    if (w_pop[gi]) begin
                        r_rd_ptr <= r_rd_ptr + PTW'(1);
                    end
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_count <= r_count + CRW'(1);
                        2'b01:   r_count <= r_count - CRW'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end

            assign w_head                                  = r_mem[r_rd_ptr];
            assign o_rsp_valid[gi]                         = (r_count != '0);
            assign o_rsp_disp[gi*DISP_BITS +: DISP_BITS]   = w_head[ENTW-1:8];
            assign o_rsp_conf[gi*8 +: 8]                   = w_head[7:0];
        end
    endgenerate

endmodule
